// File: rtl/imem_arbiter.sv
// Instruction memory access controller: arbitrates fetch vs loader onto the
// single-port memory and routes the one-cycle-late read data to its owner.
//
// rsp_owner | meaning
// ----------+---------------------------------------------------
// OWN_NONE  | no read in flight; both rvalid outputs low
// OWN_FETCH | fetch read granted last cycle; mem_rdata is fetch's
// OWN_LOAD  | loader read granted last cycle; mem_rdata is loader's
module imem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    output logic        fetch_misalign,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic        ld_lock,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    owner_t     rsp_owner, rsp_owner_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       misalign_q, misalign_nxt;

    // Grants are gated by reset_n so nothing reaches the memory during reset.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (reset_n) begin
            if (ld_lock) begin
                ld_gnt = ld_req;
            end else if (starve_cnt == STARVE_LIM && fetch_req) begin
                fetch_gnt = 1'b1;
            end else if (ld_req) begin
                ld_gnt = 1'b1;
            end else begin
                fetch_gnt = fetch_req;
            end
        end
    end

    always_comb begin
        mem_en    = fetch_gnt | ld_gnt;
        mem_we    = ld_gnt & ld_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr = ld_addr;
        end else if (fetch_gnt) begin
            mem_addr = fetch_addr;
        end
        if (mem_en) begin
            mem_wdata = ld_wdata;
        end
    end

    always_comb begin
        rsp_owner_nxt  = OWN_NONE;
        misalign_nxt   = 1'b0;
        starve_cnt_nxt = starve_cnt;
        if (fetch_gnt) begin
            rsp_owner_nxt = OWN_FETCH;
            misalign_nxt  = |fetch_addr[1:0];
        end else if (ld_gnt && !ld_we) begin
            rsp_owner_nxt = OWN_LOAD;
        end
        // The lock freezes the count so fetch's priority survives the lock.
        if (!ld_lock) begin
            if (fetch_gnt || !fetch_req) begin
                starve_cnt_nxt = '0;
            end else if (starve_cnt < STARVE_LIM) begin
                starve_cnt_nxt = starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_owner  <= OWN_NONE;
            misalign_q <= 1'b0;
            starve_cnt <= '0;
        end else begin
            rsp_owner  <= rsp_owner_nxt;
            misalign_q <= misalign_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign fetch_rvalid   = (rsp_owner == OWN_FETCH);
    assign ld_rvalid      = (rsp_owner == OWN_LOAD);
    assign fetch_rdata    = fetch_rvalid ? mem_rdata : '0;
    assign ld_rdata       = ld_rvalid ? mem_rdata : '0;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a memory model, a rule-level reference
// model checked every cycle, and literal checks for the key scenarios.
module tb_imem_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        reset_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_misalign;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_lock;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;

    imem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .fetch_misalign(fetch_misalign),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: DUT outputs are sampled mid-cycle, applied at the next edge.
    logic [31:0] env_mem [64];
    bit   [63:0] env_wr;
    logic [31:0] rdata_q = '0;
    logic        s_en = 1'b0, s_we = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;

    always @(negedge clk) begin
        s_en    <= mem_en;
        s_we    <= mem_we;
        s_addr  <= mem_addr;
        s_wdata <= mem_wdata;
    end

    always @(posedge clk) begin
        if (s_en && s_we) begin
            env_mem[s_addr[7:2]] <= s_wdata;
            env_wr[s_addr[7:2]]  <= 1'b1;
        end else if (s_en) begin
            rdata_q <= env_wr[s_addr[7:2]] ? env_mem[s_addr[7:2]] : init_word(int'(s_addr[7:2]));
        end
    end
    assign mem_rdata = rdata_q;

    // Reference model: who wins, what the word at an address is, and who
    // owns next cycle's response.
    int          ms;
    bit          e_f, e_l;
    bit          m_fv, m_lv, m_mis;
    logic [31:0] m_data = '0;
    logic [31:0] shadow [64];
    bit   [63:0] sh_wr;

    always_comb begin
        e_f = 1'b0;
        e_l = 1'b0;
        if (reset_n === 1'b1) begin
            if (ld_lock)                     e_l = ld_req;
            else if (ms == SM && fetch_req)  e_f = 1'b1;
            else if (ld_req)                 e_l = 1'b1;
            else                             e_f = fetch_req;
        end
    end

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return sh_wr[a[7:2]] ? shadow[a[7:2]] : init_word(int'(a[7:2]));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms     <= 0;
            m_fv   <= 1'b0;
            m_lv   <= 1'b0;
            m_mis  <= 1'b0;
            m_data <= '0;
        end else begin
            if (!ld_lock) begin
                if (e_f || !fetch_req) ms <= 0;
                else if (ms < SM)      ms <= ms + 1;
            end
            m_fv   <= e_f;
            m_lv   <= e_l && !ld_we;
            m_mis  <= e_f && (fetch_addr[1:0] != 2'b00);
            m_data <= model_word(e_f ? fetch_addr : ld_addr);
            if (e_l && ld_we) begin
                shadow[ld_addr[7:2]] <= ld_wdata;
                sh_wr[ld_addr[7:2]]  <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("fetch_gnt", 32'(fetch_gnt), 32'(e_f));
        chk("ld_gnt", 32'(ld_gnt), 32'(e_l));
        chk("mem_en", 32'(mem_en), 32'(e_f | e_l));
        chk("mem_we", 32'(mem_we), 32'(e_l & ld_we));
        chk("mem_addr", mem_addr, e_l ? ld_addr : (e_f ? fetch_addr : 32'h0));
        chk("mem_wdata", mem_wdata, (e_f | e_l) ? ld_wdata : 32'h0);
        chk("fetch_rvalid", 32'(fetch_rvalid), 32'(m_fv));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(m_lv));
        chk("fetch_rdata", fetch_rdata, m_fv ? m_data : 32'h0);
        chk("ld_rdata", ld_rdata, m_lv ? m_data : 32'h0);
        chk("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [9:0] pat;
    int         nf, nl;

    initial begin
        reset_n = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0; ld_lock = 1'b0;
        #3;
        chk("rst fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst ld_gnt", 32'(ld_gnt), 32'd0);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("rst ld_rvalid", 32'(ld_rvalid), 32'd0);
        tick(); tick();
        fetch_req = 1'b0; ld_req = 1'b0;
        tick();
        reset_n = 1'b1;

        fetch_req = 1'b1; fetch_addr = 32'h8;
        #1 chk("first fetch_gnt", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0;
        chk("first fetch_rvalid", 32'(fetch_rvalid), 32'd1);
        chk("first fetch_rdata", fetch_rdata, 32'hA5A5_0002);

        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
        #1 chk("wr mem_we", 32'(mem_we), 32'd1);
        tick();
        ld_req = 1'b0; ld_we = 1'b0; ld_wdata = 32'h0;
        fetch_req = 1'b1; fetch_addr = 32'h10;
        #1 chk("wr no ld_rvalid", 32'(ld_rvalid), 32'd0);
        chk("wr mem_we once", 32'(mem_we), 32'd0);
        tick();
        fetch_req = 1'b0;
        chk("raw fetch_rdata", fetch_rdata, 32'hDEAD_BEEF);

        ld_req = 1'b1; ld_addr = 32'h20; fetch_req = 1'b1; fetch_addr = 32'h24;
        nl = 0;
        for (int i = 0; i < 10; i++) begin
            #1 pat[i] = fetch_gnt;
            nl += int'(ld_gnt);
            tick();
        end
        chk("starve pattern", 32'(pat), 32'h210);
        chk("starve ld grants", 32'(nl), 32'd8);

        tick(); tick();
        ld_lock = 1'b1;
        nf = 0; nl = 0;
        for (int i = 0; i < 10; i++) begin
            #1 nf += int'(fetch_gnt);
            nl += int'(ld_gnt);
            tick();
        end
        chk("lock ld grants", 32'(nl), 32'd10);
        chk("lock fetch grants", 32'(nf), 32'd0);
        ld_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 pat[i] = fetch_gnt;
            tick();
        end
        chk("post-lock pattern", 32'(pat[2:0]), 32'h4);
        fetch_req = 1'b0; ld_req = 1'b0;
        tick();

        fetch_req = 1'b1; fetch_addr = 32'h6;
        #1 chk("misalign gnt", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0;
        chk("misalign flag", 32'(fetch_misalign), 32'd1);
        chk("misalign rvalid", 32'(fetch_rvalid), 32'd1);
        chk("misalign rdata", fetch_rdata, 32'hA5A5_0001);
        tick();

        fetch_req = 1'b1; fetch_addr = 32'hC;
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("midrst fetch_rdata", fetch_rdata, 32'd0);
        chk("midrst fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("midrst mem_en", 32'(mem_en), 32'd0);
        tick();
        chk("midrst held rvalid", 32'(fetch_rvalid), 32'd0);
        reset_n = 1'b1; fetch_req = 1'b0;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
